// File: rtl/arm_fetch_unit.sv
// ARM32 instruction fetch stage: issues word reads to a 1-cycle synchronous RAM,
// buffers responses in a small prefetch FIFO and hands them downstream over valid/ready.
module arm_fetch_unit #(
    parameter int unsigned     ARCH       = 32,
    parameter int unsigned     ADDR_W     = 12,
    parameter int unsigned     FIFO_DEPTH = 2,
    parameter logic [ARCH-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              redirect_i,
    input  logic [ARCH-1:0]   redirect_pc_i,
    output logic              ins_valid_o,
    input  logic              ins_ready_i,
    output logic [31:0]       ins_o,
    output logic [ARCH-1:0]   ins_pc_o,
    output logic [ARCH-1:0]   ins_pc8_o,
    output logic              fault_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    // Fetch-side state
    logic [ARCH-1:0] fetch_pc_q,    fetch_pc_d;
    logic            inflight_q,    inflight_d;
    logic [ARCH-1:0] inflight_pc_q, inflight_pc_d;
    logic            fault_q,       fault_d;

    // Prefetch FIFO state
    logic [CNT_W-1:0] count_q,  count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      fifo_ins_q [FIFO_DEPTH];
    logic [ARCH-1:0]  fifo_pc_q  [FIFO_DEPTH];

    logic            pop;
    logic            push;
    logic            issue;
    logic [CNT_W:0]  occ_after;
    logic [31:0]     head_ins;
    logic [ARCH-1:0] head_pc;

    assign ins_valid_o = (count_q != '0);
    assign pop         = ins_valid_o && ins_ready_i;

    // A redirect kills the response currently returning from the RAM.
    assign push = inflight_q && !redirect_i;

    // pop implies count_q >= 1, so the subtraction cannot underflow.
    assign occ_after = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
    assign issue     = reset_n && !redirect_i && !fault_q && (occ_after < DEPTH_C);

    assign mem_req_o  = issue;
    assign mem_addr_o = fetch_pc_q[ADDR_W+1:2];

    assign head_ins  = fifo_ins_q[rd_ptr_q];
    assign head_pc   = fifo_pc_q[rd_ptr_q];
    assign ins_o     = ins_valid_o ? head_ins : '0;
    assign ins_pc_o  = ins_valid_o ? head_pc : '0;
    assign ins_pc8_o = ins_valid_o ? (head_pc + ARCH'(8)) : '0;
    assign fault_o   = fault_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = fetch_pc_q;
        fault_d       = fault_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (issue) begin
            fetch_pc_d = fetch_pc_q + ARCH'(4);
        end

        if (redirect_i) begin
            // Redirect wins over any simultaneous push or pop.
            fetch_pc_d = {redirect_pc_i[ARCH-1:2], 2'b00};
            fault_d    = |redirect_pc_i[1:0];
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            fault_q       <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            fault_q       <= fault_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // NOTE: the FIFO storage has no reset; occupancy gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            fifo_ins_q[wr_ptr_q] <= mem_rdata_i;
            fifo_pc_q[wr_ptr_q]  <= inflight_pc_q;
        end
    end

    // The issue rule must always leave room for the returning response.
    assert property (@(posedge clk) disable iff (!reset_n)
        push && !pop |-> (count_q < CNT_W'(FIFO_DEPTH)));
    assert property (@(posedge clk) disable iff (!reset_n)
        count_q <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_arm_fetch_unit.sv
// Directed bench for arm_fetch_unit: stimulus loads an expected-instruction queue,
// a negedge monitor pops and compares every accepted instruction.
module tb_arm_fetch_unit;

    localparam int unsigned ARCH   = 32;
    localparam int unsigned ADDR_W = 12;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } exp_t;

    logic              clk;
    logic              reset_n;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_rdata_i;
    logic              redirect_i;
    logic [ARCH-1:0]   redirect_pc_i;
    logic              ins_valid_o;
    logic              ins_ready_i;
    logic [31:0]       ins_o;
    logic [ARCH-1:0]   ins_pc_o;
    logic [ARCH-1:0]   ins_pc8_o;
    logic              fault_o;

    logic [31:0] ram [4096];
    exp_t        exp_q [$];
    int          errors = 0;
    int          checks = 0;
    int          n_pops = 0;
    int          p0;

    arm_fetch_unit #(
        .ARCH       (ARCH),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (2),
        .RESET_PC   (32'h0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rdata_i   (mem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .ins_valid_o   (ins_valid_o),
        .ins_ready_i   (ins_ready_i),
        .ins_o         (ins_o),
        .ins_pc_o      (ins_pc_o),
        .ins_pc8_o     (ins_pc8_o),
        .fault_o       (fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction RAM: word i holds A000_0000 + i, synchronous 1-cycle read.
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'hA000_0000 + 32'(i);
        mem_rdata_i = '0;
    end
    always @(posedge clk) begin
        if (mem_req_o) mem_rdata_i <= ram[mem_addr_o];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Expected stream from a byte PC: instruction = A000_0000 + word index within RAM.
    task automatic load_stream(input logic [31:0] start);
        logic [31:0] p;
        exp_t        e;
        exp_q.delete();
        for (int i = 0; i < 48; i++) begin
            p     = start + 32'(4 * i);
            e.ins = 32'hA000_0000 + {20'd0, p[13:2]};
            e.pc  = p;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every accepted instruction must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && !redirect_i && ins_valid_o && ins_ready_i) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ins: got pc %h ins %h, expected none", ins_pc_o, ins_o);
            end else begin
                e = exp_q.pop_front();
                check("ins_o", ins_o, e.ins);
                check("ins_pc_o", ins_pc_o, e.pc);
                check("ins_pc8_o", ins_pc8_o, e.pc + 32'd8);
            end
        end
    end

    initial begin
        reset_n       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        ins_ready_i   = 1'b1;
        exp_q.delete();

        // Reset state
        repeat (2) next_cycle();
        sample();
        check("rst_valid", 32'(ins_valid_o), 32'd0);
        check("rst_ins", ins_o, 32'd0);
        check("rst_pc", ins_pc_o, 32'd0);
        check("rst_pc8", ins_pc8_o, 32'd0);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_fault", 32'(fault_o), 32'd0);

        // Release: requests from the first cycle, first valid two cycles later
        next_cycle();
        load_stream(32'h0);
        reset_n = 1'b1;
        sample();
        check("c0_req", 32'(mem_req_o), 32'd1);
        check("c0_addr", 32'(mem_addr_o), 32'd0);
        check("c0_valid", 32'(ins_valid_o), 32'd0);
        next_cycle(); sample();
        check("c1_req", 32'(mem_req_o), 32'd1);
        check("c1_addr", 32'(mem_addr_o), 32'd1);
        check("c1_valid", 32'(ins_valid_o), 32'd0);
        next_cycle(); sample();
        check("c2_valid", 32'(ins_valid_o), 32'd1);
        check("c2_addr", 32'(mem_addr_o), 32'd2);

        // Throughput: one instruction per cycle with ready held high
        next_cycle();
        p0 = n_pops;
        repeat (6) next_cycle();
        check("throughput", 32'(n_pops - p0), 32'd6);

        // Stall: requests stop, head holds
        ins_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            check("stall_req", 32'(mem_req_o), 32'd0);
            check("stall_valid", 32'(ins_valid_o), 32'd1);
            check("stall_head", ins_o, exp_q[0].ins);
            next_cycle();
        end
        ins_ready_i = 1'b1;
        repeat (4) next_cycle();

        // Redirect in steady state, simultaneous pop ignored
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        load_stream(32'h40);
        sample();
        check("redir_req_blocked", 32'(mem_req_o), 32'd0);
        next_cycle();
        redirect_i = 1'b0;
        sample();
        check("redir_valid0", 32'(ins_valid_o), 32'd0);
        check("redir_req", 32'(mem_req_o), 32'd1);
        check("redir_addr", 32'(mem_addr_o), 32'h10);
        next_cycle(); sample();
        check("redir_valid1", 32'(ins_valid_o), 32'd0);
        next_cycle(); sample();
        check("redir_valid2", 32'(ins_valid_o), 32'd1);
        check("redir_target_pc", ins_pc_o, 32'h40);
        repeat (3) next_cycle();

        // Redirect with a full FIFO
        ins_ready_i = 1'b0;
        repeat (3) next_cycle();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        load_stream(32'h100);
        next_cycle();
        redirect_i  = 1'b0;
        ins_ready_i = 1'b1;
        sample();
        check("full_redir_valid", 32'(ins_valid_o), 32'd0);
        check("full_redir_addr", 32'(mem_addr_o), 32'h40);
        repeat (4) next_cycle();

        // RAM address wrap: word 4095 -> 0, PC keeps counting
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h3FF8;
        load_stream(32'h3FF8);
        next_cycle();
        redirect_i = 1'b0;
        sample();
        check("wrap_addr0", 32'(mem_addr_o), 32'hFFE);
        next_cycle(); sample();
        check("wrap_addr1", 32'(mem_addr_o), 32'hFFF);
        next_cycle(); sample();
        check("wrap_req", 32'(mem_req_o), 32'd1);
        check("wrap_addr2", 32'(mem_addr_o), 32'h000);
        repeat (5) next_cycle();

        // Misaligned redirect: sticky fault, fetch stops
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h42;
        exp_q.delete();
        next_cycle();
        redirect_i = 1'b0;
        sample();
        check("fault_set", 32'(fault_o), 32'd1);
        check("fault_valid", 32'(ins_valid_o), 32'd0);
        for (int i = 0; i < 10; i++) begin
            next_cycle(); sample();
            check("fault_no_req", 32'(mem_req_o), 32'd0);
            check("fault_no_valid", 32'(ins_valid_o), 32'd0);
        end
        next_cycle();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h43;
        next_cycle();
        redirect_i = 1'b0;
        sample();
        check("fault_kept", 32'(fault_o), 32'd1);
        check("fault_kept_req", 32'(mem_req_o), 32'd0);

        // Aligned redirect clears the fault and resumes
        next_cycle();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h80;
        load_stream(32'h80);
        next_cycle();
        redirect_i = 1'b0;
        sample();
        check("fault_clear", 32'(fault_o), 32'd0);
        check("resume_req", 32'(mem_req_o), 32'd1);
        check("resume_addr", 32'(mem_addr_o), 32'h20);
        check("resume_valid0", 32'(ins_valid_o), 32'd0);
        next_cycle(); sample();
        check("resume_valid1", 32'(ins_valid_o), 32'd0);
        next_cycle(); sample();
        check("resume_valid2", 32'(ins_valid_o), 32'd1);
        check("resume_pc", ins_pc_o, 32'h80);
        repeat (3) next_cycle();

        // One-cycle reset pulse while the FIFO is full
        ins_ready_i = 1'b0;
        repeat (3) next_cycle();
        sample();
        check("prefull_valid", 32'(ins_valid_o), 32'd1);
        check("prefull_req", 32'(mem_req_o), 32'd0);
        next_cycle();
        reset_n = 1'b0;
        load_stream(32'h0);
        sample();
        check("pulse_req_forced", 32'(mem_req_o), 32'd0);
        next_cycle();
        reset_n = 1'b1;
        sample();
        check("pulse_valid", 32'(ins_valid_o), 32'd0);
        check("pulse_ins", ins_o, 32'd0);
        check("pulse_pc", ins_pc_o, 32'd0);
        check("pulse_fault", 32'(fault_o), 32'd0);
        check("pulse_req", 32'(mem_req_o), 32'd1);
        check("pulse_addr", 32'(mem_addr_o), 32'd0);
        next_cycle(); next_cycle();
        for (int i = 0; i < 5; i++) begin
            sample();
            check("pulse_hold_valid", 32'(ins_valid_o), 32'd1);
            check("pulse_hold_ins", ins_o, 32'hA000_0000);
            check("pulse_hold_req", 32'(mem_req_o), 32'd0);
            next_cycle();
        end
        ins_ready_i = 1'b1;
        p0 = n_pops;
        repeat (6) next_cycle();
        check("pulse_drain", 32'(n_pops - p0), 32'd6);

        ins_ready_i = 1'b0;
        repeat (2) next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
